// File: rtl/ex_operand_stage.sv
// ---------------------------------------------------------------------------
// ex_operand_stage
//
// ID/EX pipeline register plus the operand-forwarding network feeding the
// ALU wrappers. Decoded fields and register-file data are captured on the
// rising edge. The ALU operands are then formed combinationally from the
// registered fields and the live EX/MEM and MEM/WB results. The stage also
// raises a load-use hazard request and inserts one bubble per hazard.
//
// Ports
//   clk, rst_n               clock, asynchronous active-low reset
//   id_valid                 decode slot holds a real instruction
//   id_rs1, id_rs2, id_rd    source / destination register indices
//   id_rs1_data, id_rs2_data register-file read data
//   id_imm                   sign-extended immediate
//   id_alu_src               1: SrcB = immediate, 0: SrcB = rs2 value
//   id_alu_op                ALU operation code
//   id_reg_write             writeback enable
//   id_mem_read              load flag
//   stall                    hold stage contents
//   flush                    replace stage contents with a bubble
//   exmem_*                  EX/MEM forwarding source (enable, index, value)
//   memwb_*                  MEM/WB forwarding source (enable, index, value)
//   SrcA, SrcB, Operation    ALU inputs (all zero while the stage is empty)
//   ex_valid, ex_reg_write,
//   ex_mem_read, ex_rd       registered control toward EX/MEM
//   ex_store_data            forwarded rs2 value, used by stores
//   load_use_hazard          combinational hold request for decode/fetch
// ---------------------------------------------------------------------------
module ex_operand_stage #(
  parameter int DATA_WIDTH     = 32,
  parameter int OPCODE_LENGTH  = 4,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      rst_n,

  input  logic                      id_valid,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs1,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs2,
  input  logic [REG_ADDR_WIDTH-1:0] id_rd,
  input  logic [DATA_WIDTH-1:0]     id_rs1_data,
  input  logic [DATA_WIDTH-1:0]     id_rs2_data,
  input  logic [DATA_WIDTH-1:0]     id_imm,
  input  logic                      id_alu_src,
  input  logic [OPCODE_LENGTH-1:0]  id_alu_op,
  input  logic                      id_reg_write,
  input  logic                      id_mem_read,

  input  logic                      stall,
  input  logic                      flush,

  input  logic                      exmem_reg_write,
  input  logic [REG_ADDR_WIDTH-1:0] exmem_rd,
  input  logic [DATA_WIDTH-1:0]     exmem_result,
  input  logic                      memwb_reg_write,
  input  logic [REG_ADDR_WIDTH-1:0] memwb_rd,
  input  logic [DATA_WIDTH-1:0]     memwb_result,

  output logic [DATA_WIDTH-1:0]     SrcA,
  output logic [DATA_WIDTH-1:0]     SrcB,
  output logic [OPCODE_LENGTH-1:0]  Operation,
  output logic                      ex_valid,
  output logic                      ex_reg_write,
  output logic                      ex_mem_read,
  output logic [REG_ADDR_WIDTH-1:0] ex_rd,
  output logic [DATA_WIDTH-1:0]     ex_store_data,
  output logic                      load_use_hazard
);

  // Registered ID/EX contents.
  logic                      vld_p1;
  logic                      reg_write_p1;
  logic                      mem_read_p1;
  logic [REG_ADDR_WIDTH-1:0] rd_p1;
  logic [REG_ADDR_WIDTH-1:0] rs1_p1;
  logic [REG_ADDR_WIDTH-1:0] rs2_p1;
  logic [DATA_WIDTH-1:0]     rs1_data_p1;
  logic [DATA_WIDTH-1:0]     rs2_data_p1;
  logic [DATA_WIDTH-1:0]     imm_p1;
  logic                      alu_src_p1;
  logic [OPCODE_LENGTH-1:0]  alu_op_p1;

  logic                      load_bubble;
  logic [DATA_WIDTH-1:0]     rs1_fwd;
  logic [DATA_WIDTH-1:0]     rs2_fwd;

  // Select the newest value of a source register. x0 is hard-wired, so it
  // never picks up a forwarded result even if a producer names x0.
  function automatic logic [DATA_WIDTH-1:0] fwd_operand(
    input logic [REG_ADDR_WIDTH-1:0] rs,
    input logic [DATA_WIDTH-1:0]     rf_data,
    input logic                      em_we,
    input logic [REG_ADDR_WIDTH-1:0] em_rd,
    input logic [DATA_WIDTH-1:0]     em_val,
    input logic                      mw_we,
    input logic [REG_ADDR_WIDTH-1:0] mw_rd,
    input logic [DATA_WIDTH-1:0]     mw_val
  );
    logic [DATA_WIDTH-1:0] sel;
    sel = rf_data;
    if (rs != '0) begin
      if (em_we && (em_rd == rs))
        sel = em_val;
      else if (mw_we && (mw_rd == rs))
        sel = mw_val;
    end
    return sel;
  endfunction

  // A load in EX whose result is needed by the instruction in decode. rs2
  // only matters when the decode instruction actually reads it.
  assign load_use_hazard = vld_p1 && mem_read_p1 && (rd_p1 != '0) && id_valid &&
                           ((rd_p1 == id_rs1) || ((rd_p1 == id_rs2) && !id_alu_src));

  // Stall outranks the hazard bubble; flush outranks both.
  assign load_bubble = load_use_hazard && !stall;

  // ---- stage boundary: ID -> EX register ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1       <= 1'b0;
      reg_write_p1 <= 1'b0;
      mem_read_p1  <= 1'b0;
      rd_p1        <= '0;
      rs1_p1       <= '0;
      rs2_p1       <= '0;
      rs1_data_p1  <= '0;
      rs2_data_p1  <= '0;
      imm_p1       <= '0;
      alu_src_p1   <= 1'b0;
      alu_op_p1    <= '0;
    end else if (flush || load_bubble) begin
      // Bubble: only control is cleared, data fields are left as they are.
      vld_p1       <= 1'b0;
      reg_write_p1 <= 1'b0;
      mem_read_p1  <= 1'b0;
    end else if (!stall) begin
      vld_p1       <= id_valid;
      reg_write_p1 <= id_reg_write && id_valid;
      mem_read_p1  <= id_mem_read && id_valid;
      rd_p1        <= id_rd;
      rs1_p1       <= id_rs1;
      rs2_p1       <= id_rs2;
      rs1_data_p1  <= id_rs1_data;
      rs2_data_p1  <= id_rs2_data;
      imm_p1       <= id_imm;
      alu_src_p1   <= id_alu_src;
      alu_op_p1    <= id_alu_op;
    end
  end

  // ---- stage boundary: EX operand forwarding (combinational) ----
  assign rs1_fwd = fwd_operand(rs1_p1, rs1_data_p1,
                               exmem_reg_write, exmem_rd, exmem_result,
                               memwb_reg_write, memwb_rd, memwb_result);
  assign rs2_fwd = fwd_operand(rs2_p1, rs2_data_p1,
                               exmem_reg_write, exmem_rd, exmem_result,
                               memwb_reg_write, memwb_rd, memwb_result);

  // An empty stage presents all-zero operands so the idle ALU stays quiet.
  assign SrcA          = vld_p1 ? rs1_fwd : '0;
  assign SrcB          = vld_p1 ? (alu_src_p1 ? imm_p1 : rs2_fwd) : '0;
  assign ex_store_data = vld_p1 ? rs2_fwd : '0;
  assign Operation     = vld_p1 ? alu_op_p1 : '0;

  assign ex_valid      = vld_p1;
  assign ex_reg_write  = reg_write_p1;
  assign ex_mem_read   = mem_read_p1;
  assign ex_rd         = rd_p1;

endmodule

// File: tb/tb_ex_operand_stage.sv
module tb_ex_operand_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [31:0] id_rs1_data, id_rs2_data, id_imm;
  logic        id_alu_src;
  logic [3:0]  id_alu_op;
  logic        id_reg_write, id_mem_read;
  logic        stall, flush;
  logic        exmem_reg_write, memwb_reg_write;
  logic [4:0]  exmem_rd, memwb_rd;
  logic [31:0] exmem_result, memwb_result;
  logic [31:0] SrcA, SrcB, ex_store_data;
  logic [3:0]  Operation;
  logic        ex_valid, ex_reg_write, ex_mem_read, load_use_hazard;
  logic [4:0]  ex_rd;

  int checks = 0;
  int failures = 0;

  ex_operand_stage #(.DATA_WIDTH(32), .OPCODE_LENGTH(4), .REG_ADDR_WIDTH(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_alu_src(id_alu_src), .id_alu_op(id_alu_op),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .stall(stall), .flush(flush),
    .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
    .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
    .SrcA(SrcA), .SrcB(SrcB), .Operation(Operation),
    .ex_valid(ex_valid), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_rd(ex_rd), .ex_store_data(ex_store_data), .load_use_hazard(load_use_hazard)
  );

  always #5 clk = ~clk;

  // Reference model: what instruction currently occupies the EX slot.
  typedef struct packed {
    logic        valid;
    logic        rw;
    logic        mr;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] d1;
    logic [31:0] d2;
    logic [31:0] imm;
    logic        src;
    logic [3:0]  op;
  } slot_t;

  slot_t m;

  function automatic logic [31:0] newest(input logic [4:0] rs, input logic [31:0] rf);
    if (rs == 5'd0) return rf;
    if (exmem_reg_write && exmem_rd == rs) return exmem_result;
    if (memwb_reg_write && memwb_rd == rs) return memwb_result;
    return rf;
  endfunction

  function automatic logic model_hazard();
    return m.valid && m.mr && (m.rd != 5'd0) && id_valid &&
           ((m.rd == id_rs1) || (m.rd == id_rs2 && !id_alu_src));
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [31:0] ea, eb, es;
    logic [3:0]  eop;
    ea = 32'd0; eb = 32'd0; es = 32'd0; eop = 4'd0;
    if (m.valid) begin
      ea  = newest(m.rs1, m.d1);
      es  = newest(m.rs2, m.d2);
      eb  = m.src ? m.imm : es;
      eop = m.op;
    end
    chk({tag, ".SrcA"}, SrcA, ea);
    chk({tag, ".SrcB"}, SrcB, eb);
    chk({tag, ".store"}, ex_store_data, es);
    chk({tag, ".op"}, 32'(Operation), 32'(eop));
    chk({tag, ".valid"}, 32'(ex_valid), 32'(m.valid));
    chk({tag, ".rw"}, 32'(ex_reg_write), 32'(m.rw));
    chk({tag, ".mr"}, 32'(ex_mem_read), 32'(m.mr));
    if (m.valid) chk({tag, ".rd"}, 32'(ex_rd), 32'(m.rd));
    chk({tag, ".hazard"}, 32'(load_use_hazard), 32'(model_hazard()));
  endtask

  // Advance one clock; the model takes the same decision the stage should.
  task automatic tick();
    logic hz;
    hz = model_hazard();
    if (!rst_n) m = '0;
    else if (flush || (hz && !stall)) begin
      m.valid = 1'b0; m.rw = 1'b0; m.mr = 1'b0;
    end else if (!stall) begin
      m.valid = id_valid;
      m.rw    = id_reg_write & id_valid;
      m.mr    = id_mem_read & id_valid;
      m.rd    = id_rd;   m.rs1 = id_rs1; m.rs2 = id_rs2;
      m.d1    = id_rs1_data; m.d2 = id_rs2_data; m.imm = id_imm;
      m.src   = id_alu_src;  m.op = id_alu_op;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0;
    id_rs1_data = 0; id_rs2_data = 0; id_imm = 0; id_alu_src = 0; id_alu_op = 0;
    id_reg_write = 0; id_mem_read = 0; stall = 0; flush = 0;
    exmem_reg_write = 0; exmem_rd = 0; exmem_result = 0;
    memwb_reg_write = 0; memwb_rd = 0; memwb_result = 0;
  endtask

  task automatic randomize_inputs();
    id_valid        = ($urandom_range(0, 7) != 0);
    id_rs1          = 5'($urandom_range(0, 7));
    id_rs2          = 5'($urandom_range(0, 7));
    id_rd           = 5'($urandom_range(0, 7));
    id_rs1_data     = $urandom;
    id_rs2_data     = $urandom;
    id_imm          = $urandom;
    id_alu_src      = 1'($urandom_range(0, 1));
    id_alu_op       = 4'($urandom);
    id_reg_write    = 1'($urandom_range(0, 1));
    id_mem_read     = ($urandom_range(0, 2) == 0);
    stall           = ($urandom_range(0, 7) == 0);
    flush           = ($urandom_range(0, 15) == 0);
    exmem_reg_write = 1'($urandom_range(0, 1));
    exmem_rd        = 5'($urandom_range(0, 7));
    exmem_result    = $urandom;
    memwb_reg_write = 1'($urandom_range(0, 1));
    memwb_rd        = 5'($urandom_range(0, 7));
    memwb_result    = $urandom;
  endtask

  logic [31:0] held_a, held_b;

  initial begin
    m = '0;

    // Reset with random inputs: stage stays empty.
    rst_n = 0;
    randomize_inputs();
    #2;
    check_all("reset_async");
    repeat (3) begin
      randomize_inputs();
      tick();
      check_all("reset_held");
    end
    idle();
    rst_n = 1;
    tick();
    check_all("after_reset_idle");
    chk("after_reset_valid", 32'(ex_valid), 32'd0);

    // Basic pass-through.
    id_valid = 1; id_rs1 = 5'd1; id_rs2 = 5'd2; id_rd = 5'd3;
    id_rs1_data = 32'h0000_00F0; id_rs2_data = 32'h0000_000F;
    id_alu_op = 4'b0001; id_reg_write = 1;
    tick();
    chk("pass_SrcA", SrcA, 32'h0000_00F0);
    chk("pass_SrcB", SrcB, 32'h0000_000F);
    chk("pass_op", 32'(Operation), 32'h1);
    chk("pass_valid", 32'(ex_valid), 32'd1);
    check_all("pass");

    // Forwarding priority on rs1 = 5.
    id_rs1 = 5'd5; id_rs1_data = 32'h0000_0011;
    tick();
    exmem_reg_write = 1; exmem_rd = 5'd5; exmem_result = 32'hAAAA_AAAA;
    memwb_reg_write = 1; memwb_rd = 5'd5; memwb_result = 32'h5555_5555;
    #1;
    chk("fwd_exmem", SrcA, 32'hAAAA_AAAA);
    check_all("fwd_exmem");
    exmem_reg_write = 0;
    #1;
    chk("fwd_memwb", SrcA, 32'h5555_5555);
    check_all("fwd_memwb");
    id_rs1 = 5'd0; id_rs1_data = 32'h0000_0077;
    exmem_reg_write = 1; exmem_rd = 5'd0; memwb_rd = 5'd0;
    tick();
    chk("fwd_x0", SrcA, 32'h0000_0077);
    check_all("fwd_x0");

    // Immediate select with rs2 forwarded.
    idle();
    id_valid = 1; id_rs2 = 5'd6; id_alu_src = 1; id_imm = 32'hFFFF_FFFC;
    tick();
    exmem_reg_write = 1; exmem_rd = 5'd6; exmem_result = 32'h0000_1234;
    #1;
    chk("imm_SrcB", SrcB, 32'hFFFF_FFFC);
    chk("imm_store", ex_store_data, 32'h0000_1234);
    check_all("imm");

    // Load-use on x7.
    idle();
    id_valid = 1; id_rd = 5'd7; id_mem_read = 1; id_reg_write = 1;
    tick();
    id_mem_read = 0; id_rd = 5'd8; id_rs1 = 5'd7; id_rs2 = 5'd1; id_rs1_data = 32'h42;
    #1;
    chk("lu_hazard_on", 32'(load_use_hazard), 32'd1);
    check_all("lu_detect");
    tick();
    chk("lu_bubble", 32'(ex_valid), 32'd0);
    chk("lu_hazard_off", 32'(load_use_hazard), 32'd0);
    check_all("lu_bubble");
    tick();
    chk("lu_resume", 32'(ex_valid), 32'd1);
    check_all("lu_resume");

    // Stall for 3 cycles holds everything, then stall+flush gives a bubble.
    idle();
    id_valid = 1; id_rs1 = 5'd3; id_rs2 = 5'd4; id_rs1_data = 32'hCAFE_0001;
    id_rs2_data = 32'hBEEF_0002; id_alu_op = 4'b0110; id_rd = 5'd9; id_reg_write = 1;
    tick();
    held_a = SrcA; held_b = SrcB;
    stall = 1;
    id_rs1_data = 32'h1111_1111; id_rs2_data = 32'h2222_2222; id_alu_op = 4'b1111;
    repeat (3) begin
      tick();
      chk("stall_SrcA", SrcA, held_a);
      chk("stall_SrcB", SrcB, held_b);
      check_all("stall");
    end
    flush = 1;
    tick();
    chk("stall_flush_valid", 32'(ex_valid), 32'd0);
    check_all("stall_flush");

    // Asynchronous reset mid-instruction.
    idle();
    id_valid = 1; id_rs1 = 5'd2; id_rs1_data = 32'h0BAD_F00D; id_alu_op = 4'd3;
    tick();
    #2;
    rst_n = 0;
    m = '0;
    #1;
    chk("async_rst_valid", 32'(ex_valid), 32'd0);
    chk("async_rst_SrcA", SrcA, 32'd0);
    check_all("async_rst");
    rst_n = 1;
    tick();

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      randomize_inputs();
      #1;
      check_all("rand_pre");
      tick();
    end
    check_all("rand_end");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
